// File: rtl/light_intensity_controller_mc.sv
// light_intensity_controller_mc
//   Multi-channel ambient-light lamp controller. Each channel debounces its
//   sensor code, maps it to an inverse lamp target (dark sensor -> bright
//   lamp) and ramps its lamp level toward that target by one step per
//   prescaler tick. A global mode selects off / auto / manual / hold.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   en          global enable; 0 freezes prescaler, debouncers and levels
//   mode        00 off, 01 auto, 10 manual, 11 hold
//   manual_lvl  shared target for all channels in manual mode
//   sens        raw sensor codes, channel i at [i*SW +: SW]
//   lvl         registered lamp levels, channel i at [i*LW +: LW]
//   settled     per channel, level equals current target (combinational)
//   chg         one-cycle pulse after any level changed
module light_intensity_controller_mc #(
    parameter int CH       = 4,
    parameter int SW       = 4,
    parameter int LW       = 3,
    parameter int DEB      = 4,
    parameter int RAMP_DIV = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [LW-1:0]       manual_lvl,
    input  logic [CH*SW-1:0]    sens,
    output logic [CH*LW-1:0]    lvl,
    output logic [CH-1:0]       settled,
    output logic                chg
);

    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_MANUAL = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    mode_t         mode_sel;
    logic [SW-1:0] cand    [CH];
    logic [SW-1:0] acc     [CH];
    logic [CW-1:0] cnt     [CH];
    logic [LW-1:0] lvl_q   [CH];
    logic [LW-1:0] target  [CH];
    logic [LW-1:0] lvl_nxt [CH];
    logic [PW-1:0] presc;
    logic          tick;
    logic          any_step;

    assign mode_sel = mode_t'(mode);
    assign tick     = en && (presc == PW'(RAMP_DIV - 1));

    always_comb begin
        any_step = 1'b0;
        settled  = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            target[i] = '0;
            case (mode_sel)
                MODE_OFF:    target[i] = '0;
                // Inverse map of the sensor's top LW bits.
                MODE_AUTO:   target[i] = {LW{1'b1}} - acc[i][SW-1 -: LW];
                MODE_MANUAL: target[i] = manual_lvl;
                MODE_HOLD:   target[i] = lvl_q[i];
                default:     target[i] = '0;
            endcase

            lvl_nxt[i] = lvl_q[i];
            if (tick) begin
                if (lvl_q[i] < target[i])
                    lvl_nxt[i] = lvl_q[i] + LW'(1);
                else if (lvl_q[i] > target[i])
                    lvl_nxt[i] = lvl_q[i] - LW'(1);
            end

            settled[i] = (lvl_q[i] == target[i]);
            if (lvl_nxt[i] != lvl_q[i])
                any_step = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            chg   <= 1'b0;
            for (int unsigned i = 0; i < CH; i++) begin
                cand[i]  <= '0;
                cnt[i]   <= '0;
                acc[i]   <= '0;
                lvl_q[i] <= '0;
            end
        end else if (en) begin
            presc <= (presc == PW'(RAMP_DIV - 1)) ? '0 : presc + PW'(1);
            chg   <= any_step;
            for (int unsigned i = 0; i < CH; i++) begin
                lvl_q[i] <= lvl_nxt[i];
                // Counter saturates at DEB-1; acc keeps reloading the stable cand.
                if (sens[i*SW +: SW] != cand[i]) begin
                    cand[i] <= sens[i*SW +: SW];
                    cnt[i]  <= '0;
                end else if (cnt[i] == CW'(DEB - 1)) begin
                    acc[i] <= cand[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end else begin
            chg <= 1'b0;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_out
        assign lvl[g*LW +: LW] = lvl_q[g];
    end

endmodule

// File: tb/tb_light_intensity_controller_mc.sv
module tb_light_intensity_controller_mc;

    localparam int CH   = 4;
    localparam int SW   = 4;
    localparam int LW   = 3;
    localparam int DEB  = 4;
    localparam int RD   = 8;
    localparam int MAXL = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b1;
    logic [1:0]    mode = 2'b01;
    logic [LW-1:0] manual_lvl = '0;
    logic [CH*SW-1:0] sens = '0;
    logic [CH*LW-1:0] lvl;
    logic [CH-1:0] settled;
    logic          chg;

    // second configuration: fast ramp, single-edge debounce
    logic       rst2 = 1'b0;
    logic       en2  = 1'b1;
    logic [1:0] mode2 = 2'b01;
    logic [2:0] man2 = '0;
    logic [5:0] sens2 = '0;
    logic [5:0] lvl2;
    logic [1:0] settled2;
    logic       chg2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    light_intensity_controller_mc #(
        .CH(CH), .SW(SW), .LW(LW), .DEB(DEB), .RAMP_DIV(RD)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .manual_lvl(manual_lvl),
        .sens(sens), .lvl(lvl), .settled(settled), .chg(chg)
    );

    light_intensity_controller_mc #(
        .CH(2), .SW(3), .LW(3), .DEB(1), .RAMP_DIV(1)
    ) u_dut2 (
        .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .manual_lvl(man2),
        .sens(sens2), .lvl(lvl2), .settled(settled2), .chg(chg2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model of the first instance ----------------
    // Debounce expressed as a run length: a value is accepted once it has been
    // seen on DEB+1 consecutive enabled edges (reset counts as one sample of 0).
    int m_lvl [CH] = '{default: 0};
    int m_acc [CH] = '{default: 0};
    int m_last[CH] = '{default: 0};
    int m_run [CH] = '{default: 1};
    int m_k = 0;
    bit m_chg = 1'b0;

    function automatic int m_tgt(input int i);
        case (mode)
            2'b00:   return 0;
            2'b01:   return MAXL - (m_acc[i] / (1 << (SW - LW)));
            2'b10:   return int'(manual_lvl);
            default: return m_lvl[i];
        endcase
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                m_lvl[i] = 0; m_acc[i] = 0; m_last[i] = 0; m_run[i] = 1;
            end
            m_k = 0;
            m_chg = 1'b0;
        end else if (en) begin
            bit tick;
            bit changed;
            int t;
            int s;
            tick = ((m_k % RD) == RD - 1);
            changed = 1'b0;
            for (int i = 0; i < CH; i++) begin
                t = m_tgt(i);
                if (tick && m_lvl[i] < t) begin m_lvl[i]++; changed = 1'b1; end
                else if (tick && m_lvl[i] > t) begin m_lvl[i]--; changed = 1'b1; end
            end
            m_chg = changed;
            for (int i = 0; i < CH; i++) begin
                s = int'(sens[i*SW +: SW]);
                if (s == m_last[i]) begin
                    if (m_run[i] < 1000) m_run[i]++;
                end else begin
                    m_last[i] = s;
                    m_run[i] = 1;
                end
                if (m_run[i] > DEB) m_acc[i] = m_last[i];
            end
            m_k++;
        end else begin
            m_chg = 1'b0;
        end
    end

    // compare process: every falling edge, inputs are stable there
    initial forever begin
        logic [CH*LW-1:0] e_lvl;
        logic [CH-1:0]    e_set;
        @(negedge clk);
        for (int i = 0; i < CH; i++) begin
            e_lvl[i*LW +: LW] = LW'(m_lvl[i]);
            e_set[i] = (m_lvl[i] == m_tgt(i));
        end
        chk("model_lvl", 32'(lvl), 32'(e_lvl));
        chk("model_settled", 32'(settled), 32'(e_set));
        chk("model_chg", 32'(chg), 32'(m_chg));
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // bounded wait until model channel 1 reaches a level
    task automatic wait_lvl1(input int v);
        int n;
        n = 0;
        while (m_lvl[1] != v && n < 200) begin
            edges(1);
            n++;
        end
        chk("wait_lvl1_bound", 32'(m_lvl[1]), 32'(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        edges(2);
        chk("reset_lvl", 32'(lvl), 32'h000);
        chk("reset_chg", 32'(chg), 32'h0);
        chk("reset_settled", 32'(settled), 32'h0);
        rst = 1'b1;

        // ramp up 0 -> 7 in auto with dark sensors
        edges(8);
        chk("first_step", 32'(lvl), 32'h249);
        chk("first_chg", 32'(chg), 32'h1);
        edges(48);
        chk("full_ramp", 32'(lvl), 32'hFFF);
        chk("full_settled", 32'(settled), 32'hF);

        // short glitch on channel 0 is discarded
        sens[3:0] = 4'hF;
        edges(3);
        sens[3:0] = 4'h0;
        edges(12);
        chk("glitch_ignored", 32'(lvl), 32'hFFF);

        // bright sensor on channel 0 held long enough -> ramps down to 0
        sens[3:0] = 4'hF;
        edges(4 + 64);
        chk("ch0_dark_lamp", 32'(lvl), 32'hFF8);
        chk("ch0_settled", 32'(settled), 32'hF);

        // manual to 3
        mode = 2'b10;
        manual_lvl = 3'd3;
        edges(40);
        chk("manual_3", 32'(lvl), 32'h6DB);

        // head for 7, freeze at 5 with hold
        manual_lvl = 3'd7;
        wait_lvl1(5);
        mode = 2'b11;
        edges(30);
        chk("hold_5", 32'(lvl), 32'hB6D);
        chk("hold_settled", 32'(settled), 32'hF);

        // off ramps down; pause with en=0 mid-ramp
        mode = 2'b00;
        edges(20);
        en = 1'b0;
        edges(20);
        chk("pause_chg", 32'(chg), 32'h0);
        en = 1'b1;
        edges(60);
        chk("off_zero", 32'(lvl), 32'h000);
        chk("off_settled", 32'(settled), 32'hF);

        // async reset mid-ramp at level 4
        mode = 2'b01;
        sens = '0;
        wait_lvl1(4);
        rst = 1'b0;
        #1;
        chk("async_rst_lvl", 32'(lvl), 32'h000);
        chk("async_rst_chg", 32'(chg), 32'h0);
        edges(2);
        rst = 1'b1;
        edges(8);
        chk("restart_step", 32'(lvl), 32'h249);

        // second configuration
        rst2 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            edges(1);
            chk("fast_ramp", 32'(lvl2), 32'((k << 3) | k));
            chk("fast_chg", 32'(chg2), 32'h1);
        end
        edges(1);
        chk("fast_top", 32'(lvl2), 32'o77);
        chk("fast_top_chg", 32'(chg2), 32'h0);
        chk("fast_settled", 32'(settled2), 32'h3);
        sens2 = 6'o07;
        for (int j = 1; j <= 9; j++) begin
            int e0;
            edges(1);
            e0 = (j <= 2) ? 7 : ((7 - (j - 2)) > 0 ? 7 - (j - 2) : 0);
            chk("fast_deb_lvl", 32'(lvl2), 32'((7 << 3) | e0));
            if (j == 2) chk("fast_deb_settled", 32'(settled2), 32'h2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
